// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU, loader) in front of a single-port RAM with fixed read latency.
// Optional macro MEM_ARB_CPU_PRIO_EN: CPU wins every tie instead of round robin.
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int RAM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              cpu_win;
    logic              sample;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        cpu_win      = 1'b0;
        sample       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || ldr_req) begin
`ifdef MEM_ARB_CPU_PRIO_EN
                    cpu_win = cpu_req;
`else
                    // On a tie the port that did not own the last access wins.
                    cpu_win = cpu_req && (!ldr_req || (last_owner_q == OWN_LDR));
`endif
                    owner_d      = cpu_win ? OWN_CPU : OWN_LDR;
                    last_owner_d = cpu_win ? OWN_CPU : OWN_LDR;
                    req_we_d     = cpu_win ? cpu_we    : ldr_we;
                    req_addr_d   = cpu_win ? cpu_addr  : ldr_addr;
                    req_wdata_d  = cpu_win ? cpu_wdata : ldr_wdata;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (RAM_LAT == 1) begin
                    state_d = S_DONE;
                    sample  = 1'b1;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    sample  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data is captured on the edge that enters DONE, into the owner's port only.
        if (sample && !req_we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = ram_rdata;
            else                    ldr_rdata_d = ram_rdata;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_LDR;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            cnt_q        <= 3'd0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    assign ram_en    = (state_q == S_ISSUE);
    assign ram_we    = ram_en && req_we_q;
    assign ram_addr  = req_addr_q;
    assign ram_wdata = req_wdata_q;
    assign cpu_gnt   = ram_en && (owner_q == OWN_CPU);
    assign ldr_gnt   = ram_en && (owner_q == OWN_LDR);
    assign cpu_done  = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign ldr_done  = (state_q == S_DONE) && (owner_q == OWN_LDR);
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RAM_LAT=1 and a RAM model,
// one with RAM_LAT=3 whose read data is driven directly.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // RAM_LAT=1 instance signals
    logic        rst1;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [8:0]  cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_gnt, cpu_done, ldr_gnt, ldr_done;
    logic [31:0] cpu_rdata, ldr_rdata;
    logic        ram_en, ram_we, busy;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    // RAM_LAT=3 instance signals
    logic        rst3;
    logic        cpu_req3, cpu_we3, ldr_req3, ldr_we3;
    logic [8:0]  cpu_addr3, ldr_addr3;
    logic [31:0] cpu_wdata3, ldr_wdata3;
    logic        cpu_gnt3, cpu_done3, ldr_gnt3, ldr_done3;
    logic [31:0] cpu_rdata3, ldr_rdata3;
    logic        ram_en3, ram_we3, busy3;
    logic [8:0]  ram_addr3;
    logic [31:0] ram_wdata3, ram_rdata3;

    // Asynchronous-read RAM model for the RAM_LAT=1 instance
    logic [31:0] mem [512];
    logic        mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    mem_arbiter #(.DATA_W(32), .ADDR_W(9), .RAM_LAT(1)) u1 (
        .Clock(clk), .Reset(rst1),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_arbiter #(.DATA_W(32), .ADDR_W(9), .RAM_LAT(3)) u3 (
        .Clock(clk), .Reset(rst3),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_gnt(cpu_gnt3), .cpu_done(cpu_done3), .cpu_rdata(cpu_rdata3),
        .ldr_req(ldr_req3), .ldr_we(ldr_we3), .ldr_addr(ldr_addr3), .ldr_wdata(ldr_wdata3),
        .ldr_gnt(ldr_gnt3), .ldr_done(ldr_done3), .ldr_rdata(ldr_rdata3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic        exp_cpu;
    logic [31:0] exp_ldr_rd;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = '0; cpu_wdata3 = '0;
        ldr_req3 = 0; ldr_we3 = 0; ldr_addr3 = '0; ldr_wdata3 = '0;
        ram_rdata3 = 32'hBAD0_BAD0;
        tick();
        mem_init = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_gnt", {cpu_gnt, ldr_gnt}, 0);
        chk("rst_done", {cpu_done, ldr_done}, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ldr_rdata", ldr_rdata, 0);
        chk("rst3_busy", busy3, 0);
        rst1 = 1'b0; rst3 = 1'b0;

        // CPU write 0x010 <- DEADBEEF
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_cpu_gnt", cpu_gnt, 1);
        chk("wr_ldr_gnt", ldr_gnt, 0);
        chk("wr_ram_en", ram_en, 1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 9'h010);
        chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("wr_busy_issue", busy, 1);
        cpu_wdata = 32'h0BAD_0BAD; cpu_addr = 9'h0AA;
        tick();
        chk("wr_cpu_done", cpu_done, 1);
        chk("wr_cpu_gnt_off", cpu_gnt, 0);
        chk("wr_cpu_rdata", cpu_rdata, 0);
        chk("wr_ram_addr_held", ram_addr, 9'h010);
        cpu_req = 0;
        tick();
        chk("wr_idle_busy", busy, 0);
        chk("wr_done_off", cpu_done, 0);
        chk("wr_mem", mem[9'h010], 32'hDEAD_BEEF);

        // CPU read 0x010
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tick();
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_ram_we", ram_we, 0);
        tick();
        chk("rd_cpu_done", cpu_done, 1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_ldr_rdata", ldr_rdata, 0);
        cpu_req = 0;
        tick();
        chk("rd_idle_busy", busy, 0);

        // Reset clears read data and restores tie-break to CPU-first
        rst1 = 1;
        tick();
        chk("rst2_cpu_rdata", cpu_rdata, 0);
        chk("rst2_busy", busy, 0);
        rst1 = 0;

        // Both requesting, four back-to-back accesses
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        ldr_req = 1; ldr_we = 0; ldr_addr = 9'h020;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_CPU_PRIO_EN
            exp_cpu = 1'b1;
`else
            exp_cpu = (k % 2 == 0);
`endif
            tick();
            chk($sformatf("rr%0d_cpu_gnt", k), cpu_gnt, exp_cpu);
            chk($sformatf("rr%0d_ldr_gnt", k), ldr_gnt, !exp_cpu);
            tick();
            chk($sformatf("rr%0d_done", k), {cpu_done, ldr_done}, {exp_cpu, !exp_cpu});
            if (k == 3) begin
                cpu_req = 0; ldr_req = 0;
            end
            tick();
            chk($sformatf("rr%0d_idle", k), busy, 0);
        end
`ifdef MEM_ARB_CPU_PRIO_EN
        exp_ldr_rd = 32'h0;
`else
        exp_ldr_rd = 32'hA500_0020;
`endif
        chk("rr_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rr_ldr_rdata", ldr_rdata, exp_ldr_rd);

        // CPU drops req right after its grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tick();
        chk("drop_gnt", cpu_gnt, 1);
        cpu_req = 0;
        tick();
        chk("drop_done", cpu_done, 1);
        tick();
        chk("drop_done_once", cpu_done, 0);
        tick();
        chk("drop_no_regnt", {cpu_gnt, busy}, 0);

        // RAM_LAT=3: loader read 0x1FF
        ldr_req3 = 1; ldr_we3 = 0; ldr_addr3 = 9'h1FF;
        tick();
        chk("l3_gnt", ldr_gnt3, 1);
        chk("l3_ram_en_issue", ram_en3, 1);
        chk("l3_ram_addr", ram_addr3, 9'h1FF);
        chk("l3_busy_n1", busy3, 1);
        tick();
        chk("l3_ram_en_wait", ram_en3, 0);
        chk("l3_addr_held", ram_addr3, 9'h1FF);
        chk("l3_n2", {busy3, ldr_done3}, 2'b10);
        tick();
        chk("l3_n3", {busy3, ldr_done3}, 2'b10);
        ram_rdata3 = 32'h1234_5678;
        tick();
        ram_rdata3 = 32'hBAD0_BAD0;
        chk("l3_done_n4", {busy3, ldr_done3}, 2'b11);
        chk("l3_ldr_rdata", ldr_rdata3, 32'h1234_5678);
        chk("l3_cpu_rdata", cpu_rdata3, 0);
        ldr_req3 = 0;
        tick();
        chk("l3_idle", {busy3, ldr_done3}, 0);
        chk("l3_rdata_held", ldr_rdata3, 32'h1234_5678);

        // RAM_LAT=3: reset during WAIT
        cpu_req3 = 1; cpu_we3 = 0; cpu_addr3 = 9'h055;
        tick();
        chk("rw_gnt", cpu_gnt3, 1);
        tick();
        chk("rw_in_wait", {busy3, ram_en3}, 2'b10);
        rst3 = 1; cpu_req3 = 0;
        tick();
        chk("rw_busy", busy3, 0);
        chk("rw_done", {cpu_done3, ldr_done3}, 0);
        chk("rw_rdata", {cpu_rdata3, ldr_rdata3}, 0);
        rst3 = 0;
        tick();
        chk("rw_no_late_done", {busy3, cpu_done3, ldr_done3}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
